// File: rtl/dtw_pkg.sv
// Shared constants for the DTW controller: FSM encoding, CR/SR bit positions, default widths.
package dtw_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLoadRef  = 3'd1,
        StQuery    = 3'd2,
        StWaitCore = 3'd3,
        StResult   = 3'd4
    } state_e;

    localparam int unsigned CR_SOFT_RST = 0;
    localparam int unsigned CR_LOAD_REF = 1;
    localparam int unsigned CR_START    = 2;

    localparam int unsigned SR_BUSY       = 3;
    localparam int unsigned SR_REF_LOADED = 4;
    localparam int unsigned SR_DONE       = 5;
    localparam int unsigned SR_ERROR      = 6;
    localparam int unsigned SR_CNT_LSB    = 16;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_REF_ADDR_W = 15;
    localparam int unsigned DEF_QUERY_LEN  = 250;

endpackage

// File: rtl/dtw_ctrl_if.sv
// Sample stream, reference memory port, core handshake and result stream of the DTW controller.
interface dtw_ctrl_if
    import dtw_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REF_ADDR_W = DEF_REF_ADDR_W
);
    logic [DATA_W-1:0]     s_tdata;
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  s_tready;
    logic                  ref_we;
    logic [REF_ADDR_W-1:0] ref_addr;
    logic [DATA_W-1:0]     ref_din;
    logic                  core_start;
    logic                  core_q_valid;
    logic [DATA_W-1:0]     core_q_data;
    logic                  core_q_ready;
    logic                  core_done;
    logic [31:0]           core_score;
    logic [31:0]           core_pos;
    logic                  m_tvalid;
    logic [63:0]           m_tdata;
    logic                  m_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, core_q_ready, core_done, core_score, core_pos,
               m_tready,
        output s_tready, ref_we, ref_addr, ref_din, core_start, core_q_valid, core_q_data,
               m_tvalid, m_tdata
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, core_q_ready, core_done, core_score, core_pos,
               m_tready,
        input  s_tready, ref_we, ref_addr, ref_din, core_start, core_q_valid, core_q_data,
               m_tvalid, m_tdata
    );

endinterface

// File: rtl/dtw_ctrl.sv
// DTW run controller: loads the reference memory, streams query samples to the core,
// and returns the core's best score/position on a result stream.
module dtw_ctrl
    import dtw_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REF_ADDR_W = DEF_REF_ADDR_W,
    parameter int unsigned QUERY_LEN  = DEF_QUERY_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dtw_cr,
    input  logic [31:0] dtw_ref_len,
    output logic [31:0] dtw_sr,
    dtw_ctrl_if.master  bus
);

    logic        w_rst;
    logic        w_load_edge;
    logic        w_start_edge;
    logic        w_len_bad;
    logic [1:0]  r_cr_prev;
    state_e      r_state, w_state_nxt;
    logic [31:0] r_count, w_count_nxt;
    logic        r_ref_loaded, w_ref_loaded_nxt;
    logic        r_done, w_done_nxt;
    logic        r_error, w_error_nxt;
    logic        r_core_start, w_core_start_nxt;
    logic [63:0] r_result, w_result_nxt;
    logic [31:0] r_sr;
    logic        unused_cr;

    assign unused_cr    = ^dtw_cr[31:3];
    assign w_rst        = rst | dtw_cr[CR_SOFT_RST];
    assign w_load_edge  = dtw_cr[CR_LOAD_REF] & ~r_cr_prev[0];
    assign w_start_edge = dtw_cr[CR_START] & ~r_cr_prev[1];
    // Reference may fill the whole memory, so 2^REF_ADDR_W itself is legal.
    assign w_len_bad    = (dtw_ref_len == 32'd0) ||
                          ({1'b0, dtw_ref_len} > (33'd1 << REF_ADDR_W));

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_cr_prev    <= 2'b00;
            r_state      <= StIdle;
            r_count      <= 32'd0;
            r_ref_loaded <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_start <= 1'b0;
            r_result     <= 64'd0;
            r_sr         <= 32'd0;
        end else begin
            r_cr_prev    <= {dtw_cr[CR_START], dtw_cr[CR_LOAD_REF]};
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_ref_loaded <= w_ref_loaded_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_core_start <= w_core_start_nxt;
            r_result     <= w_result_nxt;
            r_sr         <= {r_count[15:0], 9'd0, r_error, r_done, r_ref_loaded,
                             (r_state != StIdle), r_state};
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_ref_loaded_nxt  = r_ref_loaded;
        w_done_nxt        = r_done;
        w_error_nxt       = r_error;
        w_core_start_nxt  = 1'b0;
        w_result_nxt      = r_result;
        bus.s_tready      = 1'b0;
        bus.ref_we        = 1'b0;
        bus.ref_addr      = '0;
        bus.ref_din       = '0;
        bus.core_q_valid  = 1'b0;
        bus.core_q_data   = '0;
        bus.m_tvalid      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_load_edge) begin
                    w_ref_loaded_nxt = 1'b0;
                    w_count_nxt      = 32'd0;
                    if (w_len_bad) w_error_nxt = 1'b1;
                    else           w_state_nxt = StLoadRef;
                end else if (w_start_edge) begin
                    if (r_ref_loaded) begin
                        w_core_start_nxt = 1'b1;
                        w_done_nxt       = 1'b0;
                        w_error_nxt      = 1'b0;
                        w_count_nxt      = 32'd0;
                        w_state_nxt      = StQuery;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            StLoadRef: begin
                bus.s_tready = 1'b1;
                bus.ref_we   = bus.s_tvalid;
                bus.ref_addr = r_count[REF_ADDR_W-1:0];
                bus.ref_din  = bus.s_tdata;
                if (bus.s_tvalid) begin
                    w_count_nxt = r_count + 32'd1;
                    // The final beat wins over a stray s_tlast.
                    if (r_count == dtw_ref_len - 32'd1) begin
                        w_ref_loaded_nxt = 1'b1;
                        w_state_nxt      = StIdle;
                    end else if (bus.s_tlast) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
            end
            StQuery: begin
                bus.core_q_valid = bus.s_tvalid;
                bus.core_q_data  = bus.s_tdata;
                bus.s_tready     = bus.core_q_ready;
                if (bus.s_tvalid && bus.core_q_ready) begin
                    w_count_nxt = r_count + 32'd1;
                    if (r_count == 32'(QUERY_LEN - 1)) begin
                        w_state_nxt = StWaitCore;
                    end else if (bus.s_tlast) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
            end
            StWaitCore: begin
                if (bus.core_done) begin
                    w_result_nxt = {bus.core_pos, bus.core_score};
                    w_state_nxt  = StResult;
                end
            end
            StResult: begin
                bus.m_tvalid = 1'b1;
                if (bus.m_tready) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign bus.core_start = r_core_start;
    assign bus.m_tdata    = r_result;
    assign dtw_sr         = r_sr;

endmodule

// File: tb/tb_dtw_ctrl.sv
// Directed bench for dtw_ctrl: table-driven reference load plus hand-written run/abort sequences.
module tb_dtw_ctrl;
    import dtw_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned QL = 8;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] data;
        logic          last;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
    } ld_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dtw_cr;
    logic [31:0] dtw_ref_len;
    logic [31:0] dtw_sr;
    int          total = 0;
    int          bad = 0;
    int          cs_cnt = 0;
    int          we_cnt = 0;
    int          mv_cnt = 0;
    ld_vec_t     ld_tab [5];

    dtw_ctrl_if #(.DATA_W(DW), .REF_ADDR_W(AW)) bus ();

    dtw_ctrl #(.DATA_W(DW), .REF_ADDR_W(AW), .QUERY_LEN(QL)) dut (
        .clk        (clk),
        .rst        (rst),
        .dtw_cr     (dtw_cr),
        .dtw_ref_len(dtw_ref_len),
        .dtw_sr     (dtw_sr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.core_start) cs_cnt <= cs_cnt + 1;
        if (bus.ref_we)     we_cnt <= we_cnt + 1;
        if (bus.m_tvalid)   mv_cnt <= mv_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load();
        dtw_ref_len = 32'd4;
        dtw_cr      = 32'h2;
        step();
        dtw_cr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bus.s_tvalid = ld_tab[i].vld;
            bus.s_tdata  = ld_tab[i].data;
            bus.s_tlast  = ld_tab[i].last;
            settle();
            check("load_tready", {63'd0, bus.s_tready}, 64'd1);
            check("load_we", {63'd0, bus.ref_we}, {63'd0, ld_tab[i].exp_we});
            if (ld_tab[i].exp_we) begin
                check("load_addr", {60'd0, bus.ref_addr}, {60'd0, ld_tab[i].exp_addr});
                check("load_din", {48'd0, bus.ref_din}, {48'd0, ld_tab[i].data});
            end
            step();
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic do_start();
        dtw_cr = 32'h4;
        step();
        dtw_cr = 32'h0;
    endtask

    task automatic send_query(input int n);
        bus.core_q_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = 16'(i);
            step();
        end
        bus.s_tvalid = 1'b0;
    endtask

    task automatic reach_result();
        do_load();
        do_start();
        send_query(QL);
        bus.core_done  = 1'b1;
        bus.core_score = 32'h1234;
        bus.core_pos   = 32'h9;
        step();
        bus.core_done = 1'b0;
        settle();
        check("result_reached", {63'd0, bus.m_tvalid}, 64'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        settle();
        check({name, "_tready"}, {63'd0, bus.s_tready}, 64'd0);
        check({name, "_qvalid"}, {63'd0, bus.core_q_valid}, 64'd0);
        check({name, "_qdata"}, {48'd0, bus.core_q_data}, 64'd0);
        check({name, "_mvalid"}, {63'd0, bus.m_tvalid}, 64'd0);
        check({name, "_mdata"}, bus.m_tdata, 64'd0);
        check({name, "_cstart"}, {63'd0, bus.core_start}, 64'd0);
        check({name, "_we"}, {63'd0, bus.ref_we}, 64'd0);
        step();
        check({name, "_sr"}, {32'd0, dtw_sr}, 64'd0);
    endtask

    initial begin
        int k;
        int cyc;
        int snap;
        logic rdy;

        ld_tab[0] = '{vld: 1'b1, data: 16'h0011, last: 1'b0, exp_we: 1'b1, exp_addr: 4'd0};
        ld_tab[1] = '{vld: 1'b0, data: 16'h00ee, last: 1'b0, exp_we: 1'b0, exp_addr: 4'd1};
        ld_tab[2] = '{vld: 1'b1, data: 16'h0022, last: 1'b0, exp_we: 1'b1, exp_addr: 4'd1};
        ld_tab[3] = '{vld: 1'b1, data: 16'h0033, last: 1'b0, exp_we: 1'b1, exp_addr: 4'd2};
        ld_tab[4] = '{vld: 1'b1, data: 16'h0044, last: 1'b1, exp_we: 1'b1, exp_addr: 4'd3};

        rst = 1'b1;
        dtw_cr = 32'h0;
        dtw_ref_len = 32'd0;
        bus.s_tdata = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        bus.core_q_ready = 1'b0;
        bus.core_done = 1'b0;
        bus.core_score = 32'd0;
        bus.core_pos = 32'd0;
        bus.m_tready = 1'b0;
        step();
        step();
        rst = 1'b0;
        settle();
        check("reset_sr", {32'd0, dtw_sr}, 64'd0);
        check("reset_mvalid", {63'd0, bus.m_tvalid}, 64'd0);
        check("reset_tready", {63'd0, bus.s_tready}, 64'd0);

        // Start without a loaded reference.
        do_start();
        step();
        check("start_unloaded_sr", {32'd0, dtw_sr}, 64'h40);
        check("start_unloaded_cs", 64'(cs_cnt), 64'd0);

        do_load();
        step();
        check("load_sr", {32'd0, dtw_sr}, 64'h0004_0050);
        check("load_idle_tready", {63'd0, bus.s_tready}, 64'd0);

        // Full run with core_q_ready toggling.
        do_start();
        settle();
        check("core_start_pulse", {63'd0, bus.core_start}, 64'd1);
        k = 0;
        cyc = 0;
        while (k < QL && cyc < 40) begin
            rdy = (cyc % 2 == 1);
            bus.core_q_ready = rdy;
            bus.s_tvalid = 1'b1;
            bus.s_tdata = 16'(16'h100 + k);
            bus.s_tlast = (k == QL - 1);
            settle();
            check("q_valid", {63'd0, bus.core_q_valid}, 64'd1);
            check("q_data", {48'd0, bus.core_q_data}, 64'(16'h100 + k));
            check("q_tready", {63'd0, bus.s_tready}, {63'd0, rdy});
            step();
            if (rdy) k++;
            cyc++;
        end
        check("q_beats", 64'(k), 64'(QL));
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        step();
        check("wait_core_sr", {32'd0, dtw_sr}, 64'h0008_001B);
        check("wait_core_mvalid", {63'd0, bus.m_tvalid}, 64'd0);
        check("run_cs_count", 64'(cs_cnt), 64'd1);
        bus.core_done = 1'b1;
        bus.core_score = 32'h64;
        bus.core_pos = 32'h7;
        step();
        bus.core_done = 1'b0;
        bus.core_score = 32'hdead;
        bus.core_pos = 32'hbeef;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("res_hold_valid", {63'd0, bus.m_tvalid}, 64'd1);
            check("res_hold_data", bus.m_tdata, 64'h0000_0007_0000_0064);
            step();
        end
        bus.m_tready = 1'b1;
        settle();
        check("res_hs_valid", {63'd0, bus.m_tvalid}, 64'd1);
        step();
        bus.m_tready = 1'b0;
        step();
        check("done_sr", {32'd0, dtw_sr}, 64'h0008_0030);
        check("done_mvalid", {63'd0, bus.m_tvalid}, 64'd0);
        bus.core_done = 1'b1;
        bus.core_score = 32'h5;
        step();
        bus.core_done = 1'b0;
        settle();
        check("idle_core_done_ignored", bus.m_tdata, 64'h0000_0007_0000_0064);

        // load_ref and start edges together: load wins.
        dtw_cr = 32'h6;
        step();
        dtw_cr = 32'h0;
        step();
        check("coincide_sr", {32'd0, dtw_sr}, 64'h0000_0029);
        check("coincide_cs", 64'(cs_cnt), 64'd1);
        for (int j = 0; j < 3; j++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata = 16'(16'hA0 + j);
            bus.s_tlast = (j == 2);
            step();
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        step();
        check("early_tlast_sr", {32'd0, dtw_sr}, 64'h0003_0060);

        snap = we_cnt;
        dtw_ref_len = 32'd0;
        dtw_cr = 32'h2;
        step();
        dtw_cr = 32'h0;
        bus.s_tvalid = 1'b1;
        bus.s_tdata = 16'h55;
        settle();
        check("len0_tready", {63'd0, bus.s_tready}, 64'd0);
        step();
        step();
        bus.s_tvalid = 1'b0;
        check("len0_no_we", 64'(we_cnt), 64'(snap));
        check("len0_sr", {32'd0, dtw_sr}, 64'h60);

        dtw_ref_len = 32'd17;
        dtw_cr = 32'h2;
        step();
        dtw_cr = 32'h0;
        step();
        check("len17_sr", {32'd0, dtw_sr}, 64'h60);

        dtw_ref_len = 32'd16;
        dtw_cr = 32'h2;
        step();
        dtw_cr = 32'h0;
        step();
        check("len16_sr", {32'd0, dtw_sr}, 64'h69);
        dtw_cr = 32'h1;
        step();
        dtw_cr = 32'h0;
        check_idle_outputs("soft_load");

        // Aborts: hard reset and soft reset in QUERY and in RESULT.
        do_load();
        do_start();
        send_query(2);
        bus.s_tvalid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("rst_query");
        bus.s_tvalid = 1'b0;

        do_load();
        do_start();
        send_query(2);
        bus.s_tvalid = 1'b1;
        dtw_cr = 32'h1;
        step();
        dtw_cr = 32'h0;
        check_idle_outputs("soft_query");
        bus.s_tvalid = 1'b0;

        reach_result();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("rst_result");

        reach_result();
        dtw_cr = 32'h1;
        step();
        dtw_cr = 32'h0;
        check_idle_outputs("soft_result");

        snap = mv_cnt;
        bus.core_done = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.core_done = 1'b0;
        check("abort_no_mvalid", 64'(mv_cnt), 64'(snap));
        check("abort_cs_count", 64'(cs_cnt), 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dtw_ctrl.md
DTW_CTRL -- requirements
Module: dtw_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width of reference and query streams.
REQ-002 SHALL have parameter REF_ADDR_W, default 15, reference memory address width.
REQ-003 SHALL have parameter QUERY_LEN, default 250, number of query samples per run.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- dtw_cr  in  32  control register; bit0 soft reset, bit1 load_ref, bit2 start.
- dtw_ref_len  in  32  reference length in samples.
- dtw_sr  out  32  status: [2:0] state, [3] busy, [4] ref_loaded, [5] done, [6] error, [31:16] beat count low bits.
- s_tdata / s_tvalid / s_tlast  in  DATA_W/1/1  sample input stream.
- s_tready  out  1  sample input ready.
- ref_we / ref_addr / ref_din  out  1/REF_ADDR_W/DATA_W  reference memory write port.
- core_start  out  1  one-cycle pulse that starts a DTW core run.
- core_q_valid / core_q_data  out  1/DATA_W  query sample to the core.
- core_q_ready  in  1  core accepts query sample.
- core_done / core_score / core_pos  in  1/32/32  core completion, best score, best position.
- m_tvalid / m_tdata  out  1/64  result stream, {core_pos, core_score}.
- m_tready  in  1  result accepted.

Function
REQ-006 SHALL edge-detect dtw_cr bits 1 and 2 against a registered copy; only rising edges act.
REQ-007 SHALL implement FSM states IDLE=0, LOAD_REF=1, QUERY=2, WAIT_CORE=3, RESULT=4.
REQ-008 IDLE: a load_ref edge SHALL clear ref_loaded, clear the count and go to LOAD_REF; when load_ref and start edges coincide, load_ref SHALL win.
REQ-009 IDLE: a start edge with ref_loaded=1 SHALL pulse core_start for exactly one cycle, clear done and error, and go to QUERY.
REQ-010 IDLE: a start edge with ref_loaded=0 SHALL set error and remain in IDLE.
REQ-011 An accepted load_ref SHALL set error and return to IDLE, without writing, when dtw_ref_len is 0 or greater than 2^REF_ADDR_W.
REQ-012 LOAD_REF: s_tready SHALL be 1; each accepted beat SHALL assert ref_we in the same cycle, with ref_addr equal to the count and ref_din equal to s_tdata; the count SHALL then increment.
REQ-013 LOAD_REF: the beat with count = dtw_ref_len-1 SHALL set ref_loaded and return to IDLE; s_tlast on that beat is ignored.
REQ-014 LOAD_REF: s_tlast on any earlier beat SHALL set error, leave ref_loaded=0, and return to IDLE.
REQ-015 QUERY: core_q_valid SHALL equal s_tvalid, core_q_data SHALL equal s_tdata, and s_tready SHALL equal core_q_ready (combinational pass-through); each accepted beat SHALL increment the count.
REQ-016 QUERY: the beat with count = QUERY_LEN-1 SHALL move to WAIT_CORE.
REQ-017 QUERY: s_tlast on an earlier beat SHALL set error and return to IDLE.
REQ-018 Outside LOAD_REF and QUERY, s_tready, ref_we and core_q_valid SHALL be 0.
REQ-019 WAIT_CORE: core_done SHALL latch core_score and core_pos and move to RESULT; core_done in any other state SHALL be ignored.
REQ-020 RESULT: m_tvalid SHALL be 1 with stable m_tdata until m_tready; on handshake the block SHALL set done and go to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 dtw_sr SHALL be registered, one cycle after the internal state.
REQ-023 done and error SHALL be sticky until the next accepted start or reset.
REQ-024 Soft reset (dtw_cr bit0 = 1) SHALL have the same effect as rst in the same cycle.

Reset
REQ-025 On rst, state SHALL be IDLE; count, ref_loaded, done, error, edge registers and latched results SHALL be 0.
REQ-026 On rst, all outputs SHALL be 0 from the next cycle.
REQ-027 rst mid-operation SHALL abort the run with no further ref_we, core_start or m_tvalid.

Structure
REQ-028 Package dtw_pkg SHALL hold the state encoding, the CR/SR bit-position constants and the default widths.
REQ-029 The block SHALL be a single module, with no sub-module.

Verification
REQ-030 ref_len=4, load_ref edge, 4 beats 0x11..0x44 -> ref_we at addr 0..3 with matching data; ref_loaded=1; state IDLE.
REQ-031 start edge with ref_loaded=0 -> error=1, no core_start, state stays IDLE.
REQ-032 loaded ref, start, QUERY_LEN beats with core_q_ready toggling every cycle, core_done with score=0x64 and pos=0x7 -> one core_start pulse; m_tdata=0x0000000700000064 held while m_tready=0 for 3 cycles; done=1 after handshake.
REQ-033 ref_len=4 with s_tlast on beat 2 -> error=1, ref_loaded=0, IDLE; ref_len=0 -> error=1, no ref_we.
REQ-034 rst and soft reset asserted in QUERY and in RESULT -> IDLE next cycle, all outputs 0, no m_tvalid.
REQ-035 load_ref and start edges in the same cycle -> LOAD_REF entered, no core_start.
